ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_LENGTH, default 32, meaning the width of the requester and RAM address buses.
REQ-002 SHALL have parameter DATA_LENGTH, default 32, meaning the width of the data buses.
REQ-003 SHALL have parameter DEPTH_WORDS, default 2048, meaning the number of RAM words.
REQ-004 SHALL have port CLK, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port if_req_valid, input, 1 bit: instruction-fetch read request.
REQ-007 SHALL have port if_req_ready, output, 1 bit: instruction-fetch request granted this cycle.
REQ-008 SHALL have port if_addr, input, ADDRESS_LENGTH bits: instruction-fetch byte address.
REQ-009 SHALL have port if_rsp_valid, output, 1 bit: instruction-fetch response strobe.
REQ-010 SHALL have port if_rsp_data, output, DATA_LENGTH bits: instruction-fetch read data.
REQ-011 SHALL have port if_rsp_err, output, 1 bit: instruction-fetch access fault.
REQ-012 SHALL have port ls_req_valid, input, 1 bit: load/store request.
REQ-013 SHALL have port ls_req_ready, output, 1 bit: load/store request granted this cycle.
REQ-014 SHALL have port ls_addr, input, ADDRESS_LENGTH bits: load/store byte address.
REQ-015 SHALL have port ls_we, input, 4 bits: byte write mask; 0 means a load.
REQ-016 SHALL have port ls_wdata, input, DATA_LENGTH bits: store data.
REQ-017 SHALL have port ls_rsp_valid, output, 1 bit: load/store response strobe (loads and stores).
REQ-018 SHALL have port ls_rsp_data, output, DATA_LENGTH bits: load data; 0 for stores.
REQ-019 SHALL have port ls_rsp_err, output, 1 bit: load/store access fault.
REQ-020 SHALL have port ram_en, output, 1 bit: RAM EN.
REQ-021 SHALL have port ram_we, output, 4 bits: RAM WE.
REQ-022 SHALL have port ram_a, output, ADDRESS_LENGTH bits: RAM word address.
REQ-023 SHALL have port ram_di, output, DATA_LENGTH bits: RAM Di.
REQ-024 SHALL have port ram_do, input, DATA_LENGTH bits: RAM Do, valid one cycle after ram_en.

Function
REQ-025 SHALL use a valid/ready handshake: a request transfers in a cycle with valid=1 and ready=1; the requester holds address/data stable until transfer; ready is combinational from valid and arbiter state.
REQ-026 SHALL grant at most one requester per cycle, with a new grant possible every cycle (fully pipelined, throughput 1 access/cycle).
REQ-027 SHALL give ls priority over if when both are valid, except as REQ-028 requires.
REQ-028 SHALL hold a 2-bit starvation counter that increments on each ls grant while if_req_valid=1 and clears on any if grant or when if_req_valid=0; at value 3 with both valid, SHALL grant if and clear.
REQ-029 SHALL drive the RAM in the grant cycle: ram_en=1, ram_a=addr>>2, ram_we=ls_we (0 for if), ram_di=ls_wdata (0 for if); with no grant, ram_en=0 and ram_we/ram_a/ram_di=0.
REQ-030 SHALL flag a fault when addr[1:0]!=0 or addr>>2 >= DEPTH_WORDS; a faulted request is still granted, but ram_en=0 and ram_we=0 in that cycle.
REQ-031 SHALL register a 1-cycle response tag (owner, is_store, err) and assert exactly one rsp_valid of the owner one cycle after each grant.
REQ-032 SHALL set rsp_data=ram_do for a non-faulted load/fetch, and 0 for a store or a fault; the err output equals the registered err; a non-owner's rsp_data/err SHALL be 0.
REQ-033 SHALL provide no response back-pressure; requesters accept rsp_valid unconditionally.
REQ-034 SHALL leave read-during-write semantics to the RAM (a store response returns 0, not old data).

Reset
REQ-035 SHALL, while RST_N=0, force ready, rsp_valid, rsp_data, rsp_err, ram_en, ram_we=0, clear the counter and response tag, and drop any in-flight response; the first grant is possible in the first CLK edge after release.

Structure
REQ-036 SHALL place owner encoding (OWN_NONE, OWN_IF, OWN_LS), STARVE_LIMIT=3 and the fault-check widths in shared package ram_arb_pkg.
REQ-037 SHALL use one sub-module, ram_arb_grant (combinational priority plus starvation counter); RAM remains external.

Verification
REQ-038 SHALL cover: if only, if_addr=0x10 -> ram_a=4, ram_en=1; next cycle if_rsp_valid=1, data=RAM[4].
REQ-039 SHALL cover: ls store ls_addr=0x20, ls_we=4'b0011, ls_wdata=0xAABBCCDD -> ram_we=4'b0011, ram_a=8; next cycle ls_rsp_valid=1, data=0; a later load returns the low halfword 0xCCDD merged into the old word.
REQ-040 SHALL cover: both valid for 8 cycles -> grant order LS,LS,LS,IF,LS,LS,LS,IF.
REQ-041 SHALL cover: ls_addr=0x2002 and ls_addr=0x2000 (DEPTH_WORDS=2048) -> granted, ram_en=0; next cycle ls_rsp_err=1, data=0.
REQ-042 SHALL cover: RST_N low one cycle after a grant -> no rsp_valid appears; after release an if request is granted on the first edge.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM port arbiter: response owner
// encoding, response tag layout, starvation limit and address-check widths.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   is_store;
    logic   err;
  } rsp_tag_t;

  localparam int STARVE_LIMIT = 3;
  localparam int CNT_W        = 2;
  localparam int ALIGN_BITS   = 2;
  localparam int WE_W         = 4;

endpackage

// File: rtl/ram_arb_grant.sv
// Fixed ls-over-if priority with a starvation counter that forces an if grant
// after STARVE_LIMIT consecutive ls grants while if is waiting.
module ram_arb_grant
  import ram_arb_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_next;

  // Grants are suppressed while reset is held so ready reads low.
  always_comb begin
    grant_if    = RST_N && if_valid &&
                  (!ls_valid || (starve_cnt == CNT_W'(STARVE_LIMIT)));
    grant_ls    = RST_N && ls_valid && !grant_if;
    starve_next = starve_cnt;
    if (grant_if || !if_valid) begin
      starve_next = '0;
    end else if (grant_ls) begin
      starve_next = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_next;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous single-port RAM between instruction fetch and
// load/store, one access per cycle, with a one-cycle registered response.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDRESS_LENGTH = 32,
  parameter int DATA_LENGTH    = 32,
  parameter int DEPTH_WORDS    = 2048
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      if_req_valid,
  output logic                      if_req_ready,
  input  logic [ADDRESS_LENGTH-1:0] if_addr,
  output logic                      if_rsp_valid,
  output logic [DATA_LENGTH-1:0]    if_rsp_data,
  output logic                      if_rsp_err,
  input  logic                      ls_req_valid,
  output logic                      ls_req_ready,
  input  logic [ADDRESS_LENGTH-1:0] ls_addr,
  input  logic [WE_W-1:0]           ls_we,
  input  logic [DATA_LENGTH-1:0]    ls_wdata,
  output logic                      ls_rsp_valid,
  output logic [DATA_LENGTH-1:0]    ls_rsp_data,
  output logic                      ls_rsp_err,
  output logic                      ram_en,
  output logic [WE_W-1:0]           ram_we,
  output logic [ADDRESS_LENGTH-1:0] ram_a,
  output logic [DATA_LENGTH-1:0]    ram_di,
  input  logic [DATA_LENGTH-1:0]    ram_do
);

  localparam logic [ADDRESS_LENGTH-1:0] DEPTH_A = ADDRESS_LENGTH'(DEPTH_WORDS);

  logic                      grant_if;
  logic                      grant_ls;
  logic [ADDRESS_LENGTH-1:0] sel_addr;
  logic [ADDRESS_LENGTH-1:0] word_addr;
  logic                      sel_fault;
  logic                      sel_store;
  rsp_tag_t                  tag;
  rsp_tag_t                  tag_next;
  logic                      data_ok;

  ram_arb_grant u_grant (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  // A faulted request still completes the handshake but never touches the RAM.
  always_comb begin
    sel_addr  = grant_ls ? ls_addr : if_addr;
    word_addr = sel_addr >> ALIGN_BITS;
    sel_fault = (sel_addr[ALIGN_BITS-1:0] != '0) || (word_addr >= DEPTH_A);
    sel_store = grant_ls && (ls_we != '0);
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_a     = '0;
    ram_di    = '0;
    if (grant_if || grant_ls) begin
      ram_en = !sel_fault;
      ram_a  = word_addr;
      if (grant_ls) begin
        ram_di = ls_wdata;
        ram_we = sel_fault ? '0 : ls_we;
      end
    end
  end

  always_comb begin
    tag_next.owner    = grant_ls ? OWN_LS : (grant_if ? OWN_IF : OWN_NONE);
    tag_next.is_store = sel_store;
    tag_next.err      = (grant_if || grant_ls) && sel_fault;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tag <= '{owner: OWN_NONE, is_store: 1'b0, err: 1'b0};
    end else begin
      tag <= tag_next;
    end
  end

  // ram_do is only meaningful for a clean read; stores and faults return zero.
  always_comb begin
    data_ok      = !tag.err && !tag.is_store;
    if_rsp_valid = (tag.owner == OWN_IF);
    ls_rsp_valid = (tag.owner == OWN_LS);
    if_rsp_err   = if_rsp_valid && tag.err;
    ls_rsp_err   = ls_rsp_valid && tag.err;
    if_rsp_data  = (if_rsp_valid && data_ok) ? ram_do : '0;
    ls_rsp_data  = (ls_rsp_valid && data_ok) ? ram_do : '0;
  end

endmodule
